l2_pmem_burst_responder: RTL
============================

Name: l2_pmem_burst_responder

Overview:
- Responder side of the L2 cache's physical-memory port. Accepts one 256-bit line read or write per request and completes it on a 64-bit burst memory port as 4 beats.
- Returns pmem_resp when the line transfer is done. Sits between the L2 cache controller and the off-chip memory model or controller.
- Supports the L2 pattern of writeback followed immediately by a fill: a new request may be issued in the cycle after pmem_resp.

Parameters:
- LINE_W, 256, line width in bits; must be a multiple of BEAT_W.
- BEAT_W, 64, burst data width in bits; BEATS = LINE_W/BEAT_W (default 4).
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with PMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pmem_address  in  32  line address from the L2; bits [4:0] ignored
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_wdata  in  LINE_W  write line, stable while pmem_write is high
- pmem_rdata  out  LINE_W  read line, valid with pmem_resp, held afterwards
- pmem_resp  out  1  one-cycle completion pulse
- bm_cmd_valid  out  1  burst command valid
- bm_cmd_ready  in  1  burst command accepted
- bm_cmd_we  out  1  1 = write burst, 0 = read burst
- bm_cmd_addr  out  32  {pmem_address[31:5], 5'b0}
- bm_wdata  out  BEAT_W  current write beat
- bm_wvalid  out  1  write beat valid
- bm_wready  in  1  write beat accepted
- bm_rdata  in  BEAT_W  read beat
- bm_rvalid  in  1  read beat valid; no backpressure
- timeout_err  out  1  sticky error flag; present only with PMEM_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, beat counter=0, pmem_rdata=0.
  - pmem_resp, bm_cmd_valid, bm_cmd_we, bm_wvalid, timeout_err=0; bm_cmd_addr=0, bm_wdata=0.
  - Reset mid-burst abandons the transfer; no pmem_resp is issued.
- IDLE: on pmem_read or pmem_write:
  - Latch address (low 5 bits zeroed), op, and pmem_wdata.
  - Go to CMD next cycle.
  - If both are high, write wins.
- CMD: bm_cmd_valid=1, with bm_cmd_addr and bm_cmd_we driven from the latched values.
  - Stay until bm_cmd_ready; the command is accepted in the cycle where valid and ready are both 1.
  - Then go to WBEAT if write, RBEAT if read.
- WBEAT: bm_wvalid=1, bm_wdata = latched line[cnt*BEAT_W +: BEAT_W], beat 0 = bits [63:0].
  - cnt increments on each wvalid&wready.
  - After beat BEATS-1 is accepted, go to RESP.
- RBEAT: each bm_rvalid writes bm_rdata into the assembly register at slice cnt, then cnt increments.
  - After beat BEATS-1, go to RESP.
  - bm_rvalid outside RBEAT is ignored.
- RESP: pmem_resp=1 for exactly one cycle.
  - For a read, pmem_rdata updates from the assembly register on entry to RESP; it is unchanged by writes.
  - Return to IDLE. A request that is still high during RESP is not re-accepted; IDLE samples requests from the next cycle.
- Latency with zero-wait memory (cmd_ready=1 and beats every cycle): request seen in cycle 0, pmem_resp in cycle 2+BEATS (cycle 6 by default).
- cnt is log2(BEATS) bits wide and resets to 0 at the end of each burst.
- pmem_* inputs are ignored outside IDLE; a change in a held request mid-transfer has no effect.

Optional Feature:
- Macro: PMEM_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on every handshake and every accepted beat, and increments in CMD, WBEAT and RBEAT otherwise.
  - When it reaches TIMEOUT_CYC, the block goes to RESP.
  - pmem_rdata=0 if the op was a read; timeout_err is set and stays set until reset.
- Without the macro: no watchdog, no timeout_err port, and the block waits indefinitely.

Test Plan:
- Read addr 0x0000_1234, cmd_ready=1, four beats 0x11..,0x22..,0x33..,0x44.. -> bm_cmd_addr=0x0000_1220, we=0; pmem_rdata={0x44..,0x33..,0x22..,0x11..}; pmem_resp pulses once in cycle 6.
- Write addr 0x0000_0040, wdata=256'h{D,C,B,A}, wready toggling 1,0,1,0,... -> beats A,B,C,D in order, each held during stalls; one resp; pmem_rdata unchanged.
- Writeback then fill: write to 0x100, then read from 0x200 issued in the cycle after resp -> two separate bursts, two resp pulses, no double accept.
- cmd_ready held low 10 cycles, spurious bm_rvalid during CMD -> no beat captured; correct line after ready.
- rst_n asserted mid-RBEAT after 2 beats -> outputs 0 immediately; a following read completes cleanly with fresh data.
- PMEM_TIMEOUT_EN, TIMEOUT_CYC=16, cmd_ready stuck low -> resp in the 17th cycle after entering CMD, pmem_rdata=0, timeout_err=1 and sticky.

Source files
------------

// File: rtl/l2_pmem_burst_responder.sv
// L2 physical-memory port responder: one LINE_W line request becomes one BEATS-beat burst.
// Optional watchdog (define PMEM_TIMEOUT_EN) force-completes a stuck burst and raises timeout_err.
module l2_pmem_burst_responder #(
  parameter int LINE_W      = 256,
  parameter int BEAT_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              bm_cmd_valid,
  input  logic              bm_cmd_ready,
  output logic              bm_cmd_we,
  output logic [31:0]       bm_cmd_addr,
  output logic [BEAT_W-1:0] bm_wdata,
  output logic              bm_wvalid,
  input  logic              bm_wready,
  input  logic [BEAT_W-1:0] bm_rdata,
  input  logic              bm_rvalid
`ifdef PMEM_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, CMD, WBEAT, RBEAT, RESP} state_e;
  typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  line_t             line_q, line_d;
  line_t             asm_q, asm_d;
  line_t             rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              wvalid_q, wvalid_d;
  logic [BEAT_W-1:0] wdata_q, wdata_d;
  logic              resp_q, resp_d;
  logic              wd_hit;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^pmem_address[4:0];

`ifdef PMEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
  assign wd_hit      = (wd_q == WD_W'(TIMEOUT_CYC));
  assign timeout_err = tmo_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    we_d        = we_q;
    cmd_valid_d = cmd_valid_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    resp_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          addr_d      = {pmem_address[31:5], 5'b0};
          we_d        = pmem_write;
          line_d      = pmem_wdata;
          cmd_valid_d = 1'b1;
          state_d     = CMD;
        end
      end
      CMD: begin
        if (bm_cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (we_q) begin
            state_d  = WBEAT;
            wvalid_d = 1'b1;
            wdata_d  = line_q[0];
          end else begin
            state_d = RBEAT;
          end
        end
      end
      WBEAT: begin
        if (bm_wready) begin
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            wvalid_d = 1'b0;
            resp_d   = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            wdata_d = line_q[cnt_d];
          end
        end
      end
      RBEAT: begin
        if (bm_rvalid) begin
          asm_d[cnt_q] = bm_rdata;
          if (cnt_q == LAST) begin
            // final beat lands in the same cycle the line is published
            cnt_d   = '0;
            rdata_d = asm_d;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef PMEM_TIMEOUT_EN
    wd_d  = '0;
    tmo_d = tmo_q;
    if (state_q == CMD || state_q == WBEAT || state_q == RBEAT) begin
      if ((state_q == CMD && bm_cmd_ready) || (state_q == WBEAT && bm_wready) ||
          (state_q == RBEAT && bm_rvalid)) begin
        wd_d = '0;
      end else if (wd_hit) begin
        state_d     = RESP;
        resp_d      = 1'b1;
        cnt_d       = '0;
        cmd_valid_d = 1'b0;
        wvalid_d    = 1'b0;
        tmo_d       = 1'b1;
        if (!we_q) rdata_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      resp_q      <= 1'b0;
`ifdef PMEM_TIMEOUT_EN
      wd_q        <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      cmd_valid_q <= cmd_valid_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
`ifdef PMEM_TIMEOUT_EN
      wd_q        <= wd_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign pmem_rdata   = rdata_q;
  assign pmem_resp    = resp_q;
  assign bm_cmd_valid = cmd_valid_q;
  assign bm_cmd_we    = we_q;
  assign bm_cmd_addr  = addr_q;
  assign bm_wdata     = wdata_q;
  assign bm_wvalid    = wvalid_q;

endmodule
